// File: rtl/i2c_poll_ctrl_pkg.sv
// Shared types and defaults for the periodic I2C sensor poller.
package i2c_poll_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StFail
  } poll_state_e;

  localparam int unsigned DefPollPeriod = 100000;
  localparam int unsigned DefTimeout    = 4096;
  localparam logic [6:0]  DefDevAddr    = 7'h48;
  localparam int unsigned SampleWidth   = 16;

endpackage

// File: rtl/i2c_poll_ctrl_timer.sv
// Up-counter with synchronous clear and a terminal-count flag at Terminal-1.
module poll_timer #(
  parameter int unsigned Terminal = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned Width = (Terminal > 2) ? $clog2(Terminal) : 1;
  localparam logic [Width-1:0] TcValue = Width'(Terminal - 1);

  logic [Width-1:0] count_d, count_q;

  // Clear wins over enable so a restart always begins from zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TcValue);

endmodule

// File: rtl/i2c_poll_ctrl.sv
// Periodic / on-demand 16-bit register reader driving an existing I2C master.
module i2c_poll_ctrl
  import i2c_poll_ctrl_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = DefPollPeriod,
  parameter int unsigned TIMEOUT     = DefTimeout,
  parameter logic [6:0]  DEV_ADDR    = DefDevAddr
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   trig_i,
  output logic                   m_start_o,
  output logic [6:0]             m_addr_o,
  input  logic                   m_done_i,
  input  logic                   m_ack_err_i,
  input  logic [SampleWidth-1:0] m_data_i,
  output logic [SampleWidth-1:0] sample_o,
  output logic                   sample_valid_o,
  output logic                   err_o,
  output logic [7:0]             err_count_o,
  output logic                   busy_o
);

  poll_state_e state_d, state_q;

  logic period_tc, timeout_tc;
  logic go, start_txn, read_ok;

  logic                   pending_d, pending_q;
  logic [SampleWidth-1:0] sample_d, sample_q;
  logic                   sv_d, sv_q;
  logic [7:0]             err_count_d, err_count_q;

  assign go        = (enable_i && period_tc) || trig_i || pending_q;
  assign start_txn = (state_q == StIdle) && go;
  assign read_ok   = (state_q == StWait) && m_done_i && !m_ack_err_i;

  poll_timer #(
    .Terminal (POLL_PERIOD)
  ) u_period_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (start_txn),
    .en_i    ((state_q == StIdle) && enable_i),
    .tc_o    (period_tc)
  );

  poll_timer #(
    .Terminal (TIMEOUT)
  ) u_timeout_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (start_txn),
    .en_i    (state_q == StWait),
    .tc_o    (timeout_tc)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // m_done is checked before the timeout so a same-cycle completion still succeeds.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (go) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait: begin
        if (m_done_i) begin
          state_d = m_ack_err_i ? StFail : StIdle;
        end else if (timeout_tc) begin
          state_d = StFail;
        end
      end
      StFail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pulses are masked while reset is held so an abandoned transaction emits nothing.
  always_comb begin
    m_start_o      = (state_q == StIssue) && !reset_i;
    err_o          = (state_q == StFail) && !reset_i;
    busy_o         = (state_q != StIdle) && !reset_i;
    sample_valid_o = sv_q && !reset_i;
  end

  always_comb begin
    pending_d = pending_q;
    if (start_txn) begin
      pending_d = 1'b0;
    end else if (trig_i && (state_q != StIdle)) begin
      pending_d = 1'b1;
    end
    sample_d    = read_ok ? m_data_i : sample_q;
    sv_d        = read_ok;
    err_count_d = err_count_q;
    if ((state_q == StFail) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_q   <= 1'b0;
      sample_q    <= '0;
      sv_q        <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      pending_q   <= pending_d;
      sample_q    <= sample_d;
      sv_q        <= sv_d;
      err_count_q <= err_count_d;
    end
  end

  assign sample_o    = sample_q;
  assign err_count_o = err_count_q;
  assign m_addr_o    = DEV_ADDR;

endmodule

// File: tb/tb_i2c_poll_ctrl.sv
// Directed bench: behavioural I2C master, cycle-accurate reference model, literal spot checks.
module tb_i2c_poll_ctrl;

  localparam int unsigned PP = 8;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        trig = 1'b0;
  logic        m_start, m_done, sample_valid, err, busy;
  logic        m_ack_err = 1'b0;
  logic [6:0]  m_addr;
  logic [15:0] m_data = 16'h0000;
  logic [15:0] sample;
  logic [7:0]  err_count;

  logic        mst_done = 1'b0;
  logic        stim_done = 1'b0;
  assign m_done = mst_done | stim_done;

  i2c_poll_ctrl #(
    .POLL_PERIOD (PP),
    .TIMEOUT     (TO),
    .DEV_ADDR    (7'h48)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .enable_i       (enable),
    .trig_i         (trig),
    .m_start_o      (m_start),
    .m_addr_o       (m_addr),
    .m_done_i       (m_done),
    .m_ack_err_i    (m_ack_err),
    .m_data_i       (m_data),
    .sample_o       (sample),
    .sample_valid_o (sample_valid),
    .err_o          (err),
    .err_count_o    (err_count),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  function automatic void check(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Behavioural master: answers lat cycles after an observed m_start (lat=0: never answers).
  int          mst_lat  = 0;
  logic        mst_nack = 1'b0;
  logic [15:0] mst_data = 16'h0000;
  int          st_cyc   = -1000;

  always @(posedge clk) begin
    #1;
    cyc++;
    mst_done  = (mst_lat != 0) && (cyc == st_cyc + mst_lat);
    m_ack_err = mst_nack;
    m_data    = mst_data;
  end

  // Observations used by the literal checks.
  int n_start = 0, n_sv = 0, n_err = 0;
  int last_trig = -1, last_err = -1;
  int start_q[$];

  // Reference model: a transaction is described by its start cycle t0 and its fail cycle.
  bit          txn = 1'b0, pend = 1'b0, sv = 1'b0;
  int          t0 = 0, fail_cyc = -1, pcnt = 0, errs = 0;
  logic [15:0] smp = 16'h0000;

  always @(negedge clk) begin
    if (cyc >= 2) begin
      check("m_start", m_start, !reset && txn && (cyc == t0));
      check("busy", busy, !reset && txn);
      check("err", err, !reset && txn && (cyc == fail_cyc));
      check("sample_valid", sample_valid, !reset && sv);
      check("sample", sample, smp);
      check("err_count", err_count, errs);
      check("m_addr", m_addr, 7'h48);
    end
    if (m_start) begin
      n_start++;
      start_q.push_back(cyc);
      st_cyc = cyc;
    end
    if (sample_valid) n_sv++;
    if (err) begin
      n_err++;
      last_err = cyc;
    end
    if (trig) last_trig = cyc;

    if (reset) begin
      txn = 0; pend = 0; sv = 0; pcnt = 0; errs = 0; smp = 16'h0000; fail_cyc = -1;
    end else begin
      sv = 0;
      if (!txn) begin
        if ((enable && pcnt == int'(PP) - 1) || trig || pend) begin
          txn = 1; t0 = cyc + 1; pcnt = 0; pend = 0; fail_cyc = -1;
        end else if (enable) begin
          pcnt++;
        end
      end else begin
        if (trig) pend = 1;
        if (cyc == fail_cyc) begin
          txn = 0;
          if (errs < 255) errs++;
        end else if (cyc > t0 && fail_cyc < 0) begin
          if (m_done) begin
            if (!m_ack_err) begin
              smp = m_data; sv = 1; txn = 0;
            end else begin
              fail_cyc = cyc + 1;
            end
          end else if (cyc == t0 + int'(TO)) begin
            fail_cyc = cyc + 1;
          end
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick(1);
    trig = 1'b0;
  endtask

  int b_start, b_sv, b_err;

  initial begin
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_sample", sample, 16'h0000);
    check("rst_err_count", err_count, 0);
    check("rst_busy", busy, 0);

    // Periodic reads: starts every 8+1+5 cycles.
    b_start = n_start; b_sv = n_sv;
    mst_lat = 5; mst_data = 16'h1A2B; mst_nack = 1'b0;
    enable = 1'b1;
    tick(60);
    enable = 1'b0;
    tick(20);
    check("per_reads", n_start - b_start, 4);
    check("per_sv", n_sv - b_sv, 4);
    check("per_interval", start_q[$] - start_q[$-1], 14);
    check("per_sample", sample, 16'h1A2B);

    // Manual trigger with enable low.
    b_start = n_start;
    pulse_trig();
    tick(30);
    check("trig_reads", n_start - b_start, 1);
    check("trig_latency", start_q[$] - last_trig, 1);

    // NACK keeps the old sample.
    b_err = n_err;
    mst_nack = 1'b1; mst_data = 16'hFFFF;
    pulse_trig();
    tick(20);
    check("nack_err_pulses", n_err - b_err, 1);
    check("nack_err_count", err_count, 1);
    check("nack_sample", sample, 16'h1A2B);

    // Two trigs during WAIT collapse into one extra read.
    b_start = n_start; b_sv = n_sv;
    mst_nack = 1'b0; mst_data = 16'h5555;
    pulse_trig();
    tick(2);
    pulse_trig();
    tick(0);
    pulse_trig();
    tick(30);
    check("pend_reads", n_start - b_start, 2);
    check("pend_sv", n_sv - b_sv, 2);
    check("pend_sample", sample, 16'h5555);

    // m_done on the timeout-expiry cycle wins.
    b_err = n_err; b_sv = n_sv;
    mst_lat = 16; mst_data = 16'h0BEE;
    pulse_trig();
    tick(30);
    check("coll_err", n_err - b_err, 0);
    check("coll_sv", n_sv - b_sv, 1);
    check("coll_sample", sample, 16'h0BEE);

    // One cycle too late: timeout already fired, late m_done ignored.
    mst_lat = 17; mst_data = 16'h7777;
    pulse_trig();
    tick(30);
    check("late_err_count", err_count, 2);
    check("late_sample", sample, 16'h0BEE);

    // Silent master: repeated timeouts saturate err_count.
    mst_lat = 0;
    enable = 1'b1;
    tick(300 * 26 + 40);
    enable = 1'b0;
    tick(40);
    check("sat_err_count", err_count, 8'hFF);
    check("sat_timeout_len", last_err - start_q[$], int'(TO) + 1);

    // Reset during WAIT, then a stale m_done.
    b_err = n_err; b_sv = n_sv;
    mst_data = 16'hDEAD;
    pulse_trig();
    tick(5);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    stim_done = 1'b1;
    tick(1);
    stim_done = 1'b0;
    tick(10);
    check("rst2_sample", sample, 16'h0000);
    check("rst2_err_count", err_count, 0);
    check("rst2_busy", busy, 0);
    check("rst2_no_sv", n_sv - b_sv, 0);
    check("rst2_no_err", n_err - b_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
